dual_port_ram_pipe: RTL
=======================

// Module: dual_port_ram_pipe
// PURPOSE
//   Parametrised true dual-port RAM; successor to the 8x16 dual-address RAM.
//   Two symmetric ports, each can independently read or write in any cycle.
//   Adds a configurable read-pipeline latency and read-during-write mode.
//   Resolves same-address write collisions and zero-fills memory after reset.
//   Sits between producer/consumer datapaths as shared scratch storage.
// PARAMETERS
//   DATA_W      8   data width per word
//   ADDR_W      4   address width; DEPTH = 2**ADDR_W words
//   RD_LAT      1   read latency in cycles, legal values 1 or 2
//   RDW_MODE    0   same-port read-during-write: 0 = old data, 1 = new data
//   WR_PRIO     0   port whose write wins on a same-address collision (0 or 1)
// PORTS
//   clk         in   1       clock, all logic on rising edge
//   rst_n       in   1       asynchronous active-low reset
//   port_en_0   in   1       port 0 access enable
//   wr_en_0     in   1       port 0 write (1) / read (0); ignored if !port_en_0
//   addr_0      in   ADDR_W  port 0 address
//   din_0       in   DATA_W  port 0 write data
//   dout_0      out  DATA_W  port 0 read data
//   dvalid_0    out  1       port 0 read data valid, one-cycle pulse per read
//   port_en_1, wr_en_1, addr_1, din_1, dout_1, dvalid_1: as port 0, for port 1
//   init_busy   out  1       high while post-reset zero-fill runs
//   collision   out  1       one-cycle pulse: same-address conflict detected
// BEHAVIOUR
//   Reset (rst_n low, async):
//     - dout_*, dvalid_*, collision = 0; init_busy = 1
//     - FSM -> CLEAR; clear counter = 0
//   FSM:
//     - CLEAR: writes 0 to addr = counter each cycle; counter +1
//       After writing DEPTH-1 -> READY; fill takes DEPTH cycles after rst_n rises.
//       All port requests are ignored: no write, no dvalid.
//     - READY: init_busy = 0; normal access. Stays in READY until reset.
//     - Reset asserted mid-CLEAR or mid-access: state aborted; CLEAR restarts at 0.
//       In-flight reads are discarded.
//   Write: port_en_x & wr_en_x -> mem[addr_x] <= din_x at that clock edge.
//   Read:  port_en_x & !wr_en_x sampled at edge N
//     - dout_x / dvalid_x update at edge N+RD_LAT-1 (RD_LAT=1: same edge,
//       registered). RD_LAT=2 adds one output register stage.
//     - Fully pipelined: one read per port per cycle accepted.
//     - dvalid_x pulses once per accepted read; dout_x holds its last value
//       while dvalid_x is low.
//   Write on port x returns no dvalid_x. dout_x updates only if RDW_MODE=1,
//   then dvalid_x stays 0.
//   Cross-port, same address, same cycle:
//     - W+W: only port WR_PRIO's data is stored; collision = 1 next cycle.
//     - R+W: the reader returns OLD data regardless of RDW_MODE; collision = 1.
//     - R+R: both return the same word; no collision.
//   Addresses are exactly ADDR_W bits: no out-of-range case and no wrap logic.
// TESTING
//   1. Reset release, DEPTH=16 -> init_busy high exactly 16 cycles; every
//      address then reads 0x00. Reads issued during CLEAR give no dvalid.
//   2. Port 0 writes i+1 to addr i (i = 0..15); port 1 reads 0..15 back-to-back
//      -> dout_1 = 1..16, dvalid_1 continuous, latency RD_LAT.
//   3. Both ports write addr 5 same cycle (0xAA on p0, 0x55 on p1), WR_PRIO=0
//      -> mem[5] = 0xAA, collision pulses one cycle; WR_PRIO=1 -> 0x55.
//   4. mem[3] = 0x11; p0 writes 0x22 to addr 3 while p1 reads addr 3
//      -> dout_1 = 0x11, collision = 1; following read -> 0x22.
//   5. RDW_MODE=1, p0 write 0x7E to addr 9 -> dout_0 = 0x7E, dvalid_0 = 0.
//      RDW_MODE=0 -> dout_0 unchanged.
//   6. Assert rst_n mid-fill (cycle 7) and mid-read-burst -> outputs 0
//      immediately; fill restarts and takes full 16 cycles after release.

Source files
------------

// File: rtl/dual_port_ram_pipe.sv
// True dual-port RAM with post-reset zero-fill, 1- or 2-cycle read latency,
// selectable same-port read-during-write data and cross-port collision flagging.
module dual_port_ram_pipe #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  parameter int WR_PRIO  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              port_en_0,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] din_0,
  output logic [DATA_W-1:0] dout_0,
  output logic              dvalid_0,
  input  logic              port_en_1,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] dout_1,
  output logic              dvalid_1,
  output logic              init_busy,
  output logic              collision
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              init_busy_q, collision_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic                         ready, same_addr, wr_wr, coll_d;
  logic [1:0]                   en, we, rd, wr_ok;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       din;

  // Port requests are invisible until the zero-fill has completed.
  assign ready     = (state_q == READY);
  assign en        = {port_en_1, port_en_0} & {2{ready}};
  assign we        = en & {wr_en_1, wr_en_0};
  assign rd        = en & ~{wr_en_1, wr_en_0};
  assign addr      = {addr_1, addr_0};
  assign din       = {din_1, din_0};
  assign same_addr = (addr_0 == addr_1);
  assign wr_wr     = we[0] & we[1] & same_addr;
  assign coll_d    = en[0] & en[1] & same_addr & (we[0] | we[1]);
  assign wr_ok[0]  = we[0] & ~(wr_wr & (WR_PRIO == 1));
  assign wr_ok[1]  = we[1] & ~(wr_wr & (WR_PRIO == 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
      collision_q <= 1'b0;
    end else begin
      collision_q <= coll_d;
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_q     <= READY;
          init_busy_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_ok[0]) mem[addr[0]] <= din[0];
      if (wr_ok[1]) mem[addr[1]] <= din[1];
    end
  end

  // Read data is taken before this edge's writes, so cross-port readers see old data.
  logic [1:0]             vld_d, upd_d, vld_s, upd_s, vld_pipe_q, upd_pipe_q, dvalid_q;
  logic [1:0][DATA_W-1:0] dat_d, dat_s, dat_pipe_q, dout_q;

  always_comb begin
    vld_d = '0;
    upd_d = '0;
    dat_d = '0;
    for (int p = 0; p < 2; p++) begin
      vld_d[p] = rd[p];
      upd_d[p] = rd[p] | (we[p] & (RDW_MODE != 0));
      dat_d[p] = rd[p] ? mem[addr[p]] : din[p];
    end
  end

  assign vld_s = (RD_LAT == 2) ? vld_pipe_q : vld_d;
  assign upd_s = (RD_LAT == 2) ? upd_pipe_q : upd_d;
  assign dat_s = (RD_LAT == 2) ? dat_pipe_q : dat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      upd_pipe_q <= '0;
      dat_pipe_q <= '0;
      dvalid_q   <= '0;
      dout_q     <= '0;
    end else begin
      vld_pipe_q <= vld_d;
      upd_pipe_q <= upd_d;
      dat_pipe_q <= dat_d;
      dvalid_q   <= vld_s;
      for (int p = 0; p < 2; p++)
        if (upd_s[p]) dout_q[p] <= dat_s[p];
    end
  end

  assign dout_0    = dout_q[0];
  assign dout_1    = dout_q[1];
  assign dvalid_0  = dvalid_q[0];
  assign dvalid_1  = dvalid_q[1];
  assign init_busy = init_busy_q;
  assign collision = collision_q;
endmodule
